// File: rtl/fp_add_issuer.sv
// Requester-side sequencer for a multi-cycle FP adder: buffers operand pairs,
// issues them with a one-cycle start pulse, captures results, recovers on timeout.
module fp_add_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] Ain,
  output logic [31:0] Bin,
  output logic        start,
  input  logic        done,
  input  logic [31:0] Ans,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [15:0]   WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t        state;
  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   wdog;
  logic          push;
  logic          pop;

  // A full FIFO refuses new data even in a cycle where the head is popped.
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (count != '0) && !res_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM; every adder-facing and downstream output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      Ain       <= '0;
      Bin       <= '0;
      start     <= 1'b0;
      res_valid <= 1'b0;
      res       <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      wdog      <= '0;
    end else begin
      start <= 1'b0;
      err   <= 1'b0;
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            Ain   <= mem_a[rd_ptr];
            Bin   <= mem_b[rd_ptr];
            start <= 1'b1;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          wdog  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 16'd1;
          if (done) begin
            res       <= Ans;
            res_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (wdog == WD_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_issuer.sv
// Self-checking bench for fp_add_issuer: directed timing sequences, a table of
// known sums, and randomized traffic against a queue-based reference model.
module tb_fp_add_issuer;

  localparam int NVEC = 6;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] Ain;
  logic [31:0] Bin;
  logic        start;
  logic        done;
  logic [31:0] Ans;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  vec_t vecs [NVEC];

  // adder_mode: 0 = bench drives done by hand, 1 = responder answers, 2 = never answers
  int          adder_mode = 1;
  int          fixed_lat  = 10;
  bit          rand_lat   = 0;
  logic        man_done;
  logic [31:0] man_ans;
  logic        rsp_done;
  logic [31:0] rsp_ans;

  logic [63:0] model_fifo [$];
  logic [31:0] pend_res   [$];
  logic [31:0] got_res    [$];
  int          push_count = 0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;

  assign done = (adder_mode == 0) ? man_done : rsp_done;
  assign Ans  = (adder_mode == 0) ? man_ans  : rsp_ans;

  fp_add_issuer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .Ain       (Ain),
    .Bin       (Bin),
    .start     (start),
    .done      (done),
    .Ans       (Ans),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res       (res),
    .busy      (busy),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [31:0] modelSum(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < NVEC; i++)
      if (vecs[i].a == a && vecs[i].b == b) return vecs[i].sum;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!in_ready && guard < 500) begin
      step();
      guard++;
    end
    checkOutput("push_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int guard = 0;
    while ((busy || res_valid || model_fifo.size() != 0) && guard < 1000) begin
      step();
      guard++;
    end
    checkOutput(name, busy | res_valid, 0);
  endtask

  // Behavioural adder: answers start after a latency, abandons the op on reset.
  initial begin
    logic [31:0] op_a;
    logic [31:0] op_b;
    int          lat;
    bit          aborted;
    rsp_done = 1'b0;
    rsp_ans  = '0;
    forever begin
      @(negedge clk);
      if (rst && start && adder_mode == 1) begin
        op_a    = Ain;
        op_b    = Bin;
        lat     = rand_lat ? int'($urandom_range(2, 8)) : fixed_lat;
        aborted = 1'b0;
        for (int k = 1; k < lat; k++) begin
          @(negedge clk);
          if (!rst) aborted = 1'b1;
        end
        if (!aborted && rst) begin
          rsp_done = 1'b1;
          rsp_ans  = modelSum(op_a, op_b);
          @(negedge clk);
          rsp_done = 1'b0;
        end
      end
    end
  end

  // Reference model: ordered queues of pushed pairs and outstanding results.
  always @(negedge clk) begin
    if (!rst) begin
      model_fifo.delete();
      pend_res.delete();
    end else begin
      if (start) begin
        if (model_fifo.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL issue_unexpected: got start=1 expected no issue (model queue empty)");
        end else begin
          logic [63:0] pair;
          pair  = model_fifo.pop_front();
          cur_a = pair[63:32];
          cur_b = pair[31:0];
          checkOutput("issue_a", Ain, cur_a);
          checkOutput("issue_b", Bin, cur_b);
          pend_res.push_back(modelSum(cur_a, cur_b));
        end
      end else if (busy) begin
        checkOutput("ain_hold", Ain, cur_a);
        checkOutput("bin_hold", Bin, cur_b);
      end
      if (err) begin
        if (pend_res.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL err_unexpected: got err=1 expected no outstanding abort");
        end else begin
          void'(pend_res.pop_front());
        end
      end
      if (res_valid && res_ready) begin
        if (pend_res.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL result_unexpected: got result %h expected none", res);
        end else begin
          checkOutput("result_order", res, pend_res.pop_front());
        end
        got_res.push_back(res);
      end
      if (in_valid && in_ready) begin
        model_fifo.push_back({in_a, in_b});
        push_count++;
      end
    end
  end

  initial begin
    logic [31:0] fill_a [5];
    logic [31:0] fill_b [5];
    int          n;
    int          seen;

    vecs[0] = '{a: 32'h3F800000, b: 32'h3F800000, sum: 32'h40000000};
    vecs[1] = '{a: 32'h40000000, b: 32'h40000000, sum: 32'h40800000};
    vecs[2] = '{a: 32'h40400000, b: 32'h3F800000, sum: 32'h40800000};
    vecs[3] = '{a: 32'h3FE00000, b: 32'h405CCCCD, sum: 32'h40A66666};
    vecs[4] = '{a: 32'h3F800000, b: 32'hBF800000, sum: 32'h00000000};
    vecs[5] = '{a: 32'h40A00000, b: 32'h40400000, sum: 32'h41000000};

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;
    man_done  = 1'b0;
    man_ans   = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_start", start, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_ain", Ain, 0);
    checkOutput("rst_bin", Bin, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    step();

    // Single operation: start one cycle after the push, done 10 cycles after start.
    applyStimulus(32'h3FE00000, 32'h405CCCCD);
    checkOutput("single_no_start_t0", start, 0);
    step();
    checkOutput("single_start_t1", start, 1);
    checkOutput("single_ain", Ain, 32'h3FE00000);
    checkOutput("single_bin", Bin, 32'h405CCCCD);
    step();
    checkOutput("single_start_t2", start, 0);
    checkOutput("single_busy_t2", busy, 1);
    n = 0;
    seen = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
      if (start) seen++;
    end
    checkOutput("single_latency", n, 9);
    checkOutput("single_extra_start", seen, 0);
    checkOutput("single_res", res, 32'h40A66666);
    checkOutput("single_ain_held", Ain, 32'h3FE00000);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checkOutput("single_drained", res_valid, 0);

    // FIFO fill with the result slot blocked downstream.
    fixed_lat = 3;
    got_res.delete();
    for (int i = 0; i < 5; i++) begin
      fill_a[i] = $urandom;
      fill_b[i] = $urandom;
      applyStimulus(fill_a[i], fill_b[i]);
    end
    checkOutput("fill_in_ready_low", in_ready, 0);
    n = 0;
    while (!res_valid && n < 40) begin
      step();
      n++;
    end
    checkOutput("fill_first_res", res, modelSum(fill_a[0], fill_b[0]));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (start) seen++;
    end
    checkOutput("fill_no_second_start", seen, 0);
    checkOutput("fill_still_full", in_ready, 0);
    res_ready = 1'b1;
    n = 0;
    while (got_res.size() < 5 && n < 300) begin
      step();
      n++;
    end
    checkOutput("fill_result_count", got_res.size(), 5);
    waitIdle("fill_idle");

    // Ordered streaming through the table of known sums.
    got_res.delete();
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i].a, vecs[i].b);
    n = 0;
    while (got_res.size() < NVEC && n < 500) begin
      step();
      n++;
    end
    checkOutput("stream_count", got_res.size(), NVEC);
    for (int i = 0; i < NVEC && i < got_res.size(); i++)
      checkOutput($sformatf("stream_%0d", i), got_res[i], vecs[i].sum);
    waitIdle("stream_idle");

    // Timeout: adder never answers; the queued second pair issues afterwards.
    adder_mode = 2;
    applyStimulus(32'h11111111, 32'h22222222);
    applyStimulus(32'h33333333, 32'h44444444);
    n = 0;
    seen = 0;
    while (!err && n < 200) begin
      step();
      n++;
      if (res_valid) seen++;
    end
    checkOutput("timeout_cycles", n, 65);
    checkOutput("timeout_res_valid", seen + int'(res_valid), 0);
    adder_mode = 1;
    fixed_lat  = 4;
    step();
    checkOutput("timeout_err_pulse", err, 0);
    checkOutput("timeout_reissue", start, 1);
    checkOutput("timeout_reissue_a", Ain, 32'h33333333);
    waitIdle("timeout_idle");

    // Spurious done in IDLE and during the START cycle.
    adder_mode = 0;
    res_ready  = 1'b0;
    man_done   = 1'b1;
    man_ans    = 32'hDEADBEEF;
    step();
    step();
    checkOutput("spur_idle", res_valid, 0);
    applyStimulus(32'h40A00000, 32'h40400000);
    step();
    checkOutput("spur_start", start, 1);
    step();
    man_done = 1'b0;
    checkOutput("spur_after_start", res_valid, 0);
    checkOutput("spur_busy", busy, 1);
    step();
    checkOutput("spur_wait", res_valid, 0);
    man_done = 1'b1;
    man_ans  = modelSum(32'h40A00000, 32'h40400000);
    step();
    man_done = 1'b0;
    checkOutput("spur_capture_valid", res_valid, 1);
    checkOutput("spur_capture_res", res, 32'h41000000);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset asserted mid-WAIT with two entries still queued.
    adder_mode = 2;
    applyStimulus(32'h01010101, 32'h02020202);
    applyStimulus(32'h03030303, 32'h04040404);
    applyStimulus(32'h05050505, 32'h06060606);
    checkOutput("rmw_in_wait", busy & ~start, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rmw_start", start, 0);
    checkOutput("rmw_busy", busy, 0);
    checkOutput("rmw_res_valid", res_valid, 0);
    checkOutput("rmw_count", 32'(dut.count), 0);
    checkOutput("rmw_in_ready", in_ready, 1);
    step();
    step();
    rst = 1'b1;
    adder_mode = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (start || busy) seen++;
    end
    checkOutput("rmw_no_reissue", seen, 0);

    // Randomized traffic against the reference model.
    rand_lat = 1;
    got_res.delete();
    push_count = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 2) == 0;
      in_a      = $urandom;
      in_b      = $urandom;
      res_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    waitIdle("rand_idle");
    checkOutput("rand_all_results", got_res.size(), push_count);
    checkOutput("rand_model_empty", model_fifo.size() + pend_res.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_issuer.md
# fp_add_issuer

Requester-side sequencer for the multi-cycle floating-point adder's start/done handshake. It buffers IEEE-754 single-precision operand pairs from an upstream valid/ready source in a small FIFO. It issues them one at a time to the adder by pulsing `start` with stable operands, captures `Ans` when `done` arrives, and presents results downstream on a valid/ready port. A watchdog counter recovers from an adder that never asserts `done`.

## Interface

Parameters:
- DEPTH, 4 — operand FIFO entries (power of two, ≥2)
- TIMEOUT, 64 — max cycles spent in WAIT before abort (1..65535)

Ports:
- clk  in  1  — single clock; all state updates on the rising edge
- rst  in  1  — asynchronous, active-low reset
- in_valid  in  1  — upstream operand pair valid
- in_ready  out  1  — FIFO can accept; `(count != DEPTH)`
- in_a  in  32  — operand A
- in_b  in  32  — operand B
- Ain  out  32  — operand A to the adder
- Bin  out  32  — operand B to the adder
- start  out  1  — one-cycle start pulse to the adder
- done  in  1  — adder completion
- Ans  in  32  — adder result, valid while `done`=1
- res_valid  out  1  — result register full
- res_ready  in  1  — downstream accepts result
- res  out  32  — captured sum
- busy  out  1  — FSM not in IDLE
- err  out  1  — one-cycle pulse on timeout abort

## Operation

- **FIFO**
  - Push when `in_valid & in_ready`; pop only on the IDLE→START transition.
  - `count` width is clog2(DEPTH+1).
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, START, WAIT.
- **IDLE**
  - Go to START when `count != 0` and `res_valid`=0; the result slot must be free before issue.
  - On that edge, pop the FIFO head into the operand registers that drive `Ain`/`Bin`.
- **START**
  - `start`=1 for exactly this cycle.
  - Clear the watchdog counter.
  - Unconditionally go to WAIT.
- **WAIT**
  - `start`=0; `Ain`/`Bin` are held stable.
  - Watchdog increments each cycle.
  - If `done`=1: capture `Ans` into `res`, set `res_valid`, return to IDLE.
  - Else if the watchdog reaches TIMEOUT−1: pulse `err`, leave `res_valid` unchanged, return to IDLE. The operation is dropped.
- `done` is ignored in IDLE and START.
- **Result slot:** `res_valid` clears on `res_valid & res_ready`. `res` holds its value until the next capture.
- `Ain`/`Bin` change only on the IDLE→START edge.

## Timing

- **Reset values:** state=IDLE, count=0, pointers=0, `Ain`=`Bin`=0, `start`=0, `res_valid`=0, `res`=0, `busy`=0, `err`=0, watchdog=0.
- All outputs are registered except `in_ready`, which is a combinational decode of `count`.
- **Issue latency:** push at edge T0 into an empty FIFO with the slot free:
  - IDLE→START at T1; `start` high in cycle T1–T2.
  - WAIT from T2.
  - `done` sampled high at edge Tn gives `res_valid`=1 after Tn.
- **Back-to-back:** IDLE is visited for at least one cycle between operations, so minimum issue spacing is 3 cycles plus adder latency.
- **Full FIFO:** `in_ready`=0 even in a cycle where a pop occurs (no same-cycle refill).
- **Simultaneous push and pop** (non-full): `count` is unchanged; both take effect.
- **Result handshake:**
  - Downstream accepting in the same cycle the FSM is in IDLE does not allow issue that cycle; issue occurs the following cycle.
  - A capture cannot coincide with a non-empty slot, because issue requires an empty slot.
- **Timeout:** with `done` never asserted, `err` pulses exactly TIMEOUT cycles after the first WAIT cycle.
- **Reset mid-operation:** asynchronous clear of all state. `start` drops immediately, and any in-flight adder result is ignored.

## Test plan

- **Single operation**
  - Stimulus: reset low 2 cycles; push `in_a`=0x3FE00000 (1.75), `in_b`=0x405CCCCD (3.45); bench adder returns `done` 10 cycles after `start` with `Ans`=0x40A66666.
  - Required: `start` high exactly one cycle, one cycle after the push; `Ain`/`Bin` match and stay stable through WAIT; `res`=0x40A66666 with `res_valid`=1.
- **FIFO fill**
  - Stimulus: hold `res_ready`=0; push 5 pairs.
  - Required: first pair issues and completes; `in_ready` drops after DEPTH=4 entries are buffered; no second `start` until `res` is drained.
- **Ordered streaming**
  - Stimulus: `res_ready`=1; push pairs (0x3F800000,0x3F800000), (0x40000000,0x40000000), (0x40400000,0x3F800000); model returns correct sums.
  - Required: results 0x40000000, 0x40800000, 0x40800000 in order, with no loss or duplication.
- **Timeout**
  - Stimulus: model never asserts `done`; TIMEOUT=64.
  - Required: one `err` pulse 64 cycles after WAIT entry; `res_valid` stays 0; next queued pair then issues.
- **Spurious done**
  - Stimulus: assert `done` with `Ans`=0xDEADBEEF while IDLE and during the START cycle.
  - Required: no capture; `res_valid` stays 0.
- **Reset mid-WAIT**
  - Stimulus: drive `rst` low during WAIT with 2 entries queued.
  - Required: `start`=0, `count`=0, `busy`=0, `res_valid`=0 immediately, without waiting for a clock edge.
